// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encodings, frame constants and counter sizing.
// Intended to be reused unchanged by the matching receiver.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_FRAME_BITS = 10;

    // Width of a counter spanning 0..clks-1, never narrower than one bit.
    function automatic int unsigned baud_cnt_width(input int unsigned clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
// A clear restarts the period so every FSM state begins on a fresh bit boundary.
module baud_counter
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned    CW   = baud_cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clear || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: accepts a byte on load/ready and shifts it out LSB first
// framed by a start and a stop bit; tx and ready come straight from flops.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in,
    input  logic       load,
    output logic       ready,
    output logic       tx
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_e state_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_idx_q;
    logic        tx_q;
    logic        ready_q;
    logic        tick;
    logic        clear_c;

    // Restart the bit timer on every state entry.
    always_comb begin
        clear_c = 1'b0;
        case (state_q)
            UART_IDLE:  clear_c = load;
            UART_START: clear_c = tick;
            UART_DATA:  clear_c = tick && (bit_idx_q == LAST_BIT);
            UART_STOP:  clear_c = tick;
            default:    clear_c = 1'b1;
        endcase
    end

    baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .clear(clear_c),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= UART_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
        end else begin
            case (state_q)
                UART_IDLE: begin
                    if (load) begin
                        shift_q   <= in;
                        bit_idx_q <= '0;
                        tx_q      <= 1'b0;
                        ready_q   <= 1'b0;
                        state_q   <= UART_START;
                    end
                end
                UART_START: begin
                    if (tick) begin
                        tx_q    <= shift_q[0];
                        state_q <= UART_DATA;
                    end
                end
                UART_DATA: begin
                    if (tick) begin
                        shift_q <= shift_q >> 1;
                        if (bit_idx_q == LAST_BIT) begin
                            tx_q    <= 1'b1;
                            state_q <= UART_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[1];
                        end
                    end
                end
                UART_STOP: begin
                    if (tick) begin
                        ready_q <= 1'b1;
                        state_q <= UART_IDLE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= UART_IDLE;
                end
            endcase
        end
    end

    assign tx    = tx_q;
    assign ready = ready_q;

endmodule
